// File: rtl/wb_arbiter_n.sv
// N-master to 1-slave Wishbone B3 classic arbiter. The grant is registered and held
// for the owner's whole cycle, with fixed-priority or round-robin selection and an optional timeout.
module wb_arbiter_n #(
  parameter int NUM_MASTERS = 2,
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 32,
  parameter int SEL_WIDTH   = DATA_WIDTH / 8,
  parameter int RR_MODE     = 0,
  parameter int TIMEOUT     = 0
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NUM_MASTERS-1:0]            m_cyc_i,
  input  logic [NUM_MASTERS-1:0]            m_stb_i,
  input  logic [NUM_MASTERS-1:0]            m_we_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_adr_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_dat_i,
  input  logic [NUM_MASTERS*SEL_WIDTH-1:0]  m_sel_i,
  output logic [DATA_WIDTH-1:0]             m_dat_o,
  output logic [NUM_MASTERS-1:0]            m_ack_o,
  output logic [NUM_MASTERS-1:0]            m_err_o,
  output logic                              s_cyc_o,
  output logic                              s_stb_o,
  output logic                              s_we_o,
  output logic [ADDR_WIDTH-1:0]             s_adr_o,
  output logic [DATA_WIDTH-1:0]             s_dat_o,
  output logic [SEL_WIDTH-1:0]              s_sel_o,
  input  logic [DATA_WIDTH-1:0]             s_dat_i,
  input  logic                              s_ack_i,
  output logic [NUM_MASTERS-1:0]            grant_o
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {IDLE, OWNED} state_t;

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]       rr_q, rr_d;
  logic [CNT_W-1:0]       tmo_q, tmo_d;
  logic [IDX_W-1:0]       owner_idx, owner_next, winner_idx;
  logic                   owned, owner_cyc, owner_stb, expire;

  // Handshake: a master transfer is live while cyc&stb are high; it completes on the
  // cycle s_ack_i is high (routed only to the owner), or aborts with a one-cycle err.
  always_comb begin
    owner_idx = '0;
    for (int k = 0; k < NUM_MASTERS; k++)
      if (grant_q[k]) owner_idx = IDX_W'(k);
  end

  always_comb begin
    int   idx;
    logic found;
    idx        = 0;
    found      = 1'b0;
    winner_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      idx = (RR_MODE != 0) ? int'(rr_q) + i : i;
      if (idx >= NUM_MASTERS) idx = idx - NUM_MASTERS;
      if (!found && m_cyc_i[idx]) begin
        winner_idx = IDX_W'(idx);
        found      = 1'b1;
      end
    end
  end

  assign owned      = (state_q == OWNED);
  assign owner_cyc  = m_cyc_i[owner_idx];
  assign owner_stb  = m_cyc_i[owner_idx] & m_stb_i[owner_idx];
  assign owner_next = (owner_idx == IDX_W'(NUM_MASTERS - 1)) ? '0 : owner_idx + 1'b1;
  // Expiry fires on the TIMEOUT-th stalled cycle; a coincident ack takes precedence.
  assign expire     = (TIMEOUT > 0) && owned && owner_stb && !s_ack_i &&
                      (tmo_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    tmo_d   = '0;
    case (state_q)
      IDLE: begin
        if (|m_cyc_i) begin
          state_d = OWNED;
          grant_d = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << winner_idx;
        end
      end
      OWNED: begin
        if (!owner_cyc || expire) begin
          state_d = IDLE;
          grant_d = '0;
          rr_d    = owner_next;
        end else if (owner_stb && !s_ack_i) begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    if (owned) begin
      s_cyc_o = owner_cyc & ~expire;
      s_stb_o = owner_stb & ~expire;
      s_we_o  = m_we_i[owner_idx];
      s_adr_o = m_adr_i[owner_idx * ADDR_WIDTH +: ADDR_WIDTH];
      s_dat_o = m_dat_i[owner_idx * DATA_WIDTH +: DATA_WIDTH];
      s_sel_o = m_sel_i[owner_idx * SEL_WIDTH +: SEL_WIDTH];
    end
  end

  assign m_dat_o = s_dat_i;
  assign m_ack_o = {NUM_MASTERS{s_ack_i}} & grant_q;
  assign m_err_o = expire ? grant_q : '0;
  assign grant_o = grant_q;

endmodule

// File: tb/tb_wb_arbiter_n.sv
// Directed bench: a 4-master fixed-priority arbiter with TIMEOUT=8 and a 3-master
// round-robin arbiter without a timeout share one clock and reset.
module tb_wb_arbiter_n;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Fixed-priority instance (A)
  logic [3:0]   a_cyc, a_stb, a_we;
  logic [127:0] a_adr;
  logic [63:0]  a_dat;
  logic [7:0]   a_sel;
  logic [15:0]  a_sdat_i, a_mdat;
  logic         a_sack;
  logic [3:0]   a_ack, a_err, a_grant;
  logic         a_scyc, a_sstb, a_swe;
  logic [31:0]  a_sadr;
  logic [15:0]  a_sdat_o;
  logic [1:0]   a_ssel;

  // Round-robin instance (B)
  logic [2:0]   b_cyc, b_stb, b_we;
  logic [95:0]  b_adr;
  logic [47:0]  b_dat;
  logic [5:0]   b_sel;
  logic [15:0]  b_sdat_i, b_mdat;
  logic         b_sack;
  logic [2:0]   b_ack, b_err, b_grant;
  logic         b_scyc, b_sstb, b_swe;
  logic [31:0]  b_sadr;
  logic [15:0]  b_sdat_o;
  logic [1:0]   b_ssel;

  int n_cmp = 0;
  int n_mis = 0;

  wb_arbiter_n #(.NUM_MASTERS(4), .DATA_WIDTH(16), .ADDR_WIDTH(32), .RR_MODE(0), .TIMEOUT(8)) dut_a (
    .clk_i(clk), .rst_i(rst),
    .m_cyc_i(a_cyc), .m_stb_i(a_stb), .m_we_i(a_we),
    .m_adr_i(a_adr), .m_dat_i(a_dat), .m_sel_i(a_sel),
    .m_dat_o(a_mdat), .m_ack_o(a_ack), .m_err_o(a_err),
    .s_cyc_o(a_scyc), .s_stb_o(a_sstb), .s_we_o(a_swe),
    .s_adr_o(a_sadr), .s_dat_o(a_sdat_o), .s_sel_o(a_ssel),
    .s_dat_i(a_sdat_i), .s_ack_i(a_sack), .grant_o(a_grant)
  );

  wb_arbiter_n #(.NUM_MASTERS(3), .DATA_WIDTH(16), .ADDR_WIDTH(32), .RR_MODE(1), .TIMEOUT(0)) dut_b (
    .clk_i(clk), .rst_i(rst),
    .m_cyc_i(b_cyc), .m_stb_i(b_stb), .m_we_i(b_we),
    .m_adr_i(b_adr), .m_dat_i(b_dat), .m_sel_i(b_sel),
    .m_dat_o(b_mdat), .m_ack_o(b_ack), .m_err_o(b_err),
    .s_cyc_o(b_scyc), .s_stb_o(b_sstb), .s_we_o(b_swe),
    .s_adr_o(b_sadr), .s_dat_o(b_sdat_o), .s_sel_o(b_ssel),
    .s_dat_i(b_sdat_i), .s_ack_i(b_sack), .grant_o(b_grant)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs changed afterwards apply at the next edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL time_limit observed=running expected=finished");
    $fatal(1, "time limit");
  end

  initial begin
    a_cyc = '0; a_stb = '0; a_we = '0; a_adr = '0; a_dat = '0; a_sel = '0;
    a_sdat_i = '0; a_sack = 1'b0;
    b_cyc = '0; b_stb = '0; b_we = '0; b_adr = '0; b_dat = '0; b_sel = '0;
    b_sdat_i = '0; b_sack = 1'b0;

    // Reset for two cycles
    step(); step();
    chk("rst_grant_a", 64'(a_grant), 64'h0);
    chk("rst_scyc_a", 64'(a_scyc), 64'h0);
    chk("rst_grant_b", 64'(b_grant), 64'h0);
    rst = 1'b0;

    // Single master 1 read of 0x100, slave acks 0xBEEF on the third owned cycle
    a_cyc[1] = 1'b1; a_stb[1] = 1'b1; a_adr[32 +: 32] = 32'h100; a_sel[2 +: 2] = 2'b11;
    settle();
    chk("single_latency_scyc", 64'(a_scyc), 64'h0);
    step();
    chk("single_grant", 64'(a_grant), 64'h2);
    chk("single_scyc", 64'(a_scyc), 64'h1);
    chk("single_sadr", 64'(a_sadr), 64'h100);
    chk("single_swe", 64'(a_swe), 64'h0);
    chk("single_no_early_ack", 64'(a_ack), 64'h0);
    step(); step();
    a_sack = 1'b1; a_sdat_i = 16'hBEEF;
    settle();
    chk("single_ack", 64'(a_ack), 64'h2);
    chk("single_rdata", 64'(a_mdat), 64'hBEEF);
    a_cyc[1] = 1'b0; a_stb[1] = 1'b0; a_sack = 1'b0;
    step();
    chk("single_release_grant", 64'(a_grant), 64'h0);
    chk("single_release_ack", 64'(a_ack), 64'h0);

    // Fixed priority: masters 1 and 3 together, master 3 writes
    a_cyc[1] = 1'b1; a_stb[1] = 1'b1;
    a_cyc[3] = 1'b1; a_stb[3] = 1'b1; a_we[3] = 1'b1;
    a_adr[96 +: 32] = 32'h300; a_dat[48 +: 16] = 16'hA5A5; a_sel[6 +: 2] = 2'b01;
    step();
    chk("fp_first_grant", 64'(a_grant), 64'h2);
    step();
    chk("fp_locked_grant", 64'(a_grant), 64'h2);
    a_cyc[1] = 1'b0; a_stb[1] = 1'b0;
    step();
    chk("fp_dead_grant", 64'(a_grant), 64'h0);
    chk("fp_dead_scyc", 64'(a_scyc), 64'h0);
    step();
    chk("fp_second_grant", 64'(a_grant), 64'h8);
    chk("fp_second_sadr", 64'(a_sadr), 64'h300);
    chk("fp_second_sdat", 64'(a_sdat_o), 64'hA5A5);
    chk("fp_second_ssel", 64'(a_ssel), 64'h1);
    chk("fp_second_swe", 64'(a_swe), 64'h1);
    a_cyc[3] = 1'b0; a_stb[3] = 1'b0; a_we[3] = 1'b0;
    step();

    // Locked block cycle: master 0 takes 4 acked beats while master 1 waits
    a_cyc[0] = 1'b1; a_stb[0] = 1'b1; a_adr[0 +: 32] = 32'h40;
    a_cyc[1] = 1'b1; a_stb[1] = 1'b1;
    step();
    chk("blk_grant", 64'(a_grant), 64'h1);
    chk("blk_sadr", 64'(a_sadr), 64'h40);
    for (int beat = 0; beat < 4; beat++) begin
      a_sack = 1'b1;
      settle();
      chk("blk_beat_grant", 64'(a_grant), 64'h1);
      chk("blk_beat_ack", 64'(a_ack), 64'h1);
      step();
    end
    a_sack = 1'b0; a_cyc[0] = 1'b0; a_stb[0] = 1'b0;
    step();
    chk("blk_release", 64'(a_grant), 64'h0);
    step();
    chk("blk_next_owner", 64'(a_grant), 64'h2);
    a_cyc[1] = 1'b0; a_stb[1] = 1'b0;
    step();

    // Timeout: master 0 strobes, slave never acks
    a_cyc[0] = 1'b1; a_stb[0] = 1'b1;
    step();
    chk("tmo_grant", 64'(a_grant), 64'h1);
    repeat (6) step();
    chk("tmo_cycle7_err", 64'(a_err), 64'h0);
    chk("tmo_cycle7_scyc", 64'(a_scyc), 64'h1);
    step();
    chk("tmo_cycle8_err", 64'(a_err), 64'h1);
    chk("tmo_cycle8_scyc", 64'(a_scyc), 64'h0);
    chk("tmo_cycle8_sstb", 64'(a_sstb), 64'h0);
    chk("tmo_cycle8_ack", 64'(a_ack), 64'h0);
    a_cyc[0] = 1'b0; a_stb[0] = 1'b0;
    step();
    chk("tmo_idle_grant", 64'(a_grant), 64'h0);
    chk("tmo_idle_err", 64'(a_err), 64'h0);
    step();
    chk("tmo_stays_idle", 64'(a_grant), 64'h0);

    // Timeout boundary: ack on the 8th stalled cycle wins
    a_cyc[0] = 1'b1; a_stb[0] = 1'b1;
    step();
    repeat (7) step();
    a_sack = 1'b1; a_sdat_i = 16'h1234;
    settle();
    chk("tmo_ack_ack", 64'(a_ack), 64'h1);
    chk("tmo_ack_err", 64'(a_err), 64'h0);
    chk("tmo_ack_scyc", 64'(a_scyc), 64'h1);
    chk("tmo_ack_rdata", 64'(a_mdat), 64'h1234);
    a_sack = 1'b0; a_cyc[0] = 1'b0; a_stb[0] = 1'b0;
    step();
    chk("tmo_ack_release", 64'(a_grant), 64'h0);

    // Reset mid-transaction, then a late ack
    a_cyc[0] = 1'b1; a_stb[0] = 1'b1;
    step();
    chk("rmid_grant", 64'(a_grant), 64'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rmid_grant_cleared", 64'(a_grant), 64'h0);
    chk("rmid_scyc", 64'(a_scyc), 64'h0);
    a_sack = 1'b1;
    settle();
    chk("rmid_late_ack", 64'(a_ack), 64'h0);
    chk("rmid_late_err", 64'(a_err), 64'h0);
    a_sack = 1'b0;
    step();
    chk("rmid_resume_grant", 64'(a_grant), 64'h1);
    chk("rmid_resume_scyc", 64'(a_scyc), 64'h1);
    a_cyc[0] = 1'b0; a_stb[0] = 1'b0;
    step();

    // Round-robin fairness on B: all request, each releases after one ack
    b_cyc = 3'b111; b_stb = 3'b111;
    b_adr = {32'h2000, 32'h1000, 32'h0000};
    b_sdat_i = 16'h5A5A;
    step();
    for (int i = 0; i < 6; i++) begin
      int exp_owner;
      exp_owner = i % 3;
      chk("rr_grant", 64'(b_grant), 64'(3'b001 << exp_owner));
      chk("rr_sadr", 64'(b_sadr), 64'(32'h1000 * exp_owner));
      b_sack = 1'b1;
      settle();
      chk("rr_ack", 64'(b_ack), 64'(3'b001 << exp_owner));
      b_cyc[exp_owner] = 1'b0; b_stb[exp_owner] = 1'b0; b_sack = 1'b0;
      step();
      chk("rr_gap", 64'(b_grant), 64'h0);
      b_cyc[exp_owner] = 1'b1; b_stb[exp_owner] = 1'b1;
      step();
    end
    chk("rr_err_never", 64'(b_err), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
